ifu_mem_rsp: RTL and testbench

Memory-side responder for the instruction-fetch cache's line-refill interface. It accepts line-fill requests (mem_reqTag*), queues them, and returns the matching instruction line on mem_rspInsLine* with tag echo after a fixed latency. Lines are held in an internal line array that the bench or loader preloads through a write port. It sits between ifu_cache and the instruction memory and is the bench's memory model.

---
 rtl/ifu_mem_rsp.sv | 113 +++++++++++
 tb/tb_ifu_mem_rsp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_mem_rsp.sv
// ifu_mem_rsp: fixed-latency line-refill responder with preloadable line array and request FIFO.
// IFU_MEM_RSP_DUP_FILTER_EN discards requests whose tag is already queued.
module ifu_mem_rsp #(
    parameter int ADDR_WIDTH = 32,
    parameter int OFFSET_WIDTH = 4,
    parameter int TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH,
    parameter int LINE_WIDTH = 128,
    parameter int MEM_LINES = 1024,
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int RSP_LATENCY = 3
) (
    input  logic                                Clock,
    input  logic                                Rst,
    input  logic [TAG_WIDTH-1:0]                mem_reqTagIn,
    input  logic                                mem_reqTagValidIn,
    output logic                                mem_reqTagReadyOut,
    output logic [TAG_WIDTH-1:0]                mem_rspTagOut,
    output logic [LINE_WIDTH-1:0]               mem_rspInsLineOut,
    output logic                                mem_rspInsLineValidOut,
    input  logic                                wrEnIn,
    input  logic [$clog2(MEM_LINES)-1:0]        wrIdxIn,
    input  logic [LINE_WIDTH-1:0]               wrLineIn,
    output logic                                overflowOut,
    output logic [$clog2(REQ_FIFO_DEPTH):0]     pendingCntOut
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
    localparam int CNT_W = $clog2(RSP_LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [TAG_WIDTH-1:0] fifo [REQ_FIFO_DEPTH];
    logic [LINE_WIDTH-1:0] mem [MEM_LINES];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [PTR_W:0] count, countNext;
    logic [TAG_WIDTH-1:0] headTag;
    logic push, pop, dup, load;

    assign headTag = fifo[rdPtr];
    assign mem_reqTagReadyOut = count != (PTR_W+1)'(REQ_FIFO_DEPTH);
    assign push = mem_reqTagValidIn && mem_reqTagReadyOut && !dup;
    assign pop = state == RESP;
    assign countNext = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign mem_rspInsLineValidOut = state == RESP;
    assign pendingCntOut = count;

`ifdef IFU_MEM_RSP_DUP_FILTER_EN
    // Only occupied slots (head onward, count entries) take part in the match.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < REQ_FIFO_DEPTH; i++)
            if ((PTR_W+1)'(i) < count && fifo[rdPtr + PTR_W'(i)] == mem_reqTagIn) dup = 1'b1;
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        cntNext = cnt;
        load = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                stateNext = WAIT;
                cntNext = CNT_W'(RSP_LATENCY - 2);
            end
            WAIT: if (cnt == '0) begin
                stateNext = RESP;
                load = 1'b1;
            end else cntNext = cnt - 1'b1;
            RESP: begin
                stateNext = countNext != '0 ? WAIT : IDLE;
                cntNext = CNT_W'(RSP_LATENCY - 2);
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state <= IDLE;
            cnt <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            overflowOut <= 1'b0;
            mem_rspTagOut <= '0;
            mem_rspInsLineOut <= '0;
        end else begin
            state <= stateNext;
            cnt <= cntNext;
            count <= countNext;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (mem_reqTagValidIn && !mem_reqTagReadyOut) overflowOut <= 1'b1;
            // Array read happens before this edge's preload write lands.
            if (load) begin
                mem_rspTagOut <= headTag;
                mem_rspInsLineOut <= mem[headTag[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push) fifo[wrPtr] <= mem_reqTagIn;
    end

    always_ff @(posedge Clock) begin
        if (wrEnIn) mem[wrIdxIn] <= wrLineIn;
    end
endmodule

// File: tb/tb_ifu_mem_rsp.sv
// tb_ifu_mem_rsp: scoreboard bench with a transaction-level timing/occupancy model.
module tb_ifu_mem_rsp;
    localparam int TW = 28;
    localparam int LW = 128;
    localparam int IW = 10;
    localparam int DEPTH = 4;
    localparam int LAT = 3;

    logic Clock = 1'b0;
    logic Rst = 1'b1;
    logic [TW-1:0] mem_reqTagIn = '0;
    logic mem_reqTagValidIn = 1'b0;
    logic mem_reqTagReadyOut;
    logic [TW-1:0] mem_rspTagOut;
    logic [LW-1:0] mem_rspInsLineOut;
    logic mem_rspInsLineValidOut;
    logic wrEnIn = 1'b0;
    logic [IW-1:0] wrIdxIn = '0;
    logic [LW-1:0] wrLineIn = '0;
    logic overflowOut;
    logic [2:0] pendingCntOut;

    ifu_mem_rsp dut (
        .Clock(Clock), .Rst(Rst),
        .mem_reqTagIn(mem_reqTagIn), .mem_reqTagValidIn(mem_reqTagValidIn),
        .mem_reqTagReadyOut(mem_reqTagReadyOut),
        .mem_rspTagOut(mem_rspTagOut), .mem_rspInsLineOut(mem_rspInsLineOut),
        .mem_rspInsLineValidOut(mem_rspInsLineValidOut),
        .wrEnIn(wrEnIn), .wrIdxIn(wrIdxIn), .wrLineIn(wrLineIn),
        .overflowOut(overflowOut), .pendingCntOut(pendingCntOut)
    );

    always #5 Clock = ~Clock;

    int edgeCnt = 0;
    always @(posedge Clock) edgeCnt <= edgeCnt + 1;

    typedef struct {
        logic [TW-1:0] tag;
        logic [LW-1:0] line;
        int respEdge;
    } expT;

    expT sb[$];
    expT pend[$];
    logic [LW-1:0] refMem [1024];
    bit ovfModel = 0;
    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edgeCnt);
        end
    endtask

    // Model: FIFO occupancy is the set of accepted requests not yet popped;
    // a request's response edge is LAT after acceptance or LAT after the previous response.
    task automatic step(input bit v, input logic [TW-1:0] tag, input bit we,
                        input logic [IW-1:0] idx, input logic [LW-1:0] line, input bit rst);
        int t;
        bit dupM;
        expT e;
        expT keep[$];
        @(negedge Clock);
        t = edgeCnt + 1;
        while (pend.size() > 0 && pend[0].respEdge + 1 < t) void'(pend.pop_front());
        if (edgeCnt >= 1) begin
            check("ready", mem_reqTagReadyOut, pend.size() < DEPTH);
            check("pending", pendingCntOut, pend.size());
            check("overflow", overflowOut, ovfModel);
        end
        Rst = rst;
        mem_reqTagValidIn = v;
        mem_reqTagIn = tag;
        wrEnIn = we;
        wrIdxIn = idx;
        wrLineIn = line;
        if (rst) begin
            pend.delete();
            ovfModel = 0;
            foreach (sb[i]) if (sb[i].respEdge < t) keep.push_back(sb[i]);
            sb = keep;
        end else if (v) begin
            dupM = 0;
`ifdef IFU_MEM_RSP_DUP_FILTER_EN
            foreach (pend[i]) if (pend[i].tag == tag) dupM = 1;
`endif
            if (pend.size() >= DEPTH) ovfModel = 1;
            else if (!dupM) begin
                e.tag = tag;
                e.line = refMem[tag[IW-1:0]];
                e.respEdge = pend.size() == 0 ? t + LAT : pend[$].respEdge + LAT;
                pend.push_back(e);
                sb.push_back(e);
            end
        end
        if (we) refMem[idx] = line;
    endtask

    task automatic idle();
        step(0, '0, 0, '0, '0, 0);
    endtask

    task automatic req(input logic [TW-1:0] tag);
        step(1, tag, 0, '0, '0, 0);
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [LW-1:0] line);
        step(0, '0, 1, idx, line, 0);
    endtask

    task automatic rstCyc();
        step(0, '0, 0, '0, '0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) idle();
        idle();
        check("drain_outstanding", sb.size(), 0);
    endtask

    always @(negedge Clock) begin
        if (mem_rspInsLineValidOut === 1'b1) begin
            if (sb.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("FAIL unexpected_rsp: got tag %0h with nothing outstanding (edge %0d)", mem_rspTagOut, edgeCnt);
            end else begin
                expT e;
                e = sb.pop_front();
                check("rsp_tag", mem_rspTagOut, e.tag);
                check("rsp_line", mem_rspInsLineOut, e.line);
                check("rsp_edge", edgeCnt, e.respEdge);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r;
        logic [TW-1:0] tg;
        foreach (refMem[i]) refMem[i] = 'x;
        rstCyc();
        rstCyc();
        wr(10'h005, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        rstCyc();
        rstCyc();
        idle();
        check("rst_valid", mem_rspInsLineValidOut, 0);
        check("rst_tag", mem_rspTagOut, 0);
        check("rst_line", mem_rspInsLineOut, 0);
        req(28'h5);
        drain();

        wr(10'h100, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        req(28'h100);
        drain();

        for (int i = 0; i < 4; i++) wr(IW'(i), 128'hA5A5A5A5 + LW'(i));
        for (int i = 0; i < 5; i++) req(TW'(i));
        drain();
        check("overflow_sticky", overflowOut, 1);

        wr(10'h3FF, 128'hCAFEF00D_0000_1111_2222_3333_4444_5555);
        req(28'h0FFF);
        drain();

        wr(10'h010, 128'h01D0_01D0);
        req(28'h10);
        r = sb[$].respEdge;
        while (edgeCnt + 2 < r) idle();
        wr(10'h010, 128'h0E30_0E30);
        drain();
        req(28'h10);
        drain();

        wr(10'h020, 128'h2020_2020);
        for (int i = 0; i < 3; i++) req(28'h20);
        drain();

        req(28'h30);
        idle();
        rstCyc();
        for (int i = 0; i < 6; i++) idle();
        check("post_rst_outstanding", sb.size(), 0);

        for (int i = 0; i < 16; i++) wr(IW'(i), {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 300; i++) begin
            tg = $urandom_range(0, 3) == 0 ? TW'($urandom & 32'h0FFFFC0F) : TW'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) req(tg);
            else idle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
